// File: rtl/nes_ppu_pkg.sv
// Shared widths, constants and small helpers for the NES pixel/palette path.
package nes_ppu_pkg;

  localparam int unsigned PAL_ADDR_W = 5;
  localparam int unsigned COLOR_W    = 6;
  localparam int unsigned PIX_W      = 2;

  // Universal backdrop entry; the mirrored 0x10/14/18/1C slots are never addressed.
  localparam logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = 5'h00;

  // Grayscale keeps only the luma row of the NES colour index.
  localparam logic [COLOR_W-1:0] GRAY_MASK = 6'h30;

  // Sideband bit positions within sync_in / sync_out.
  localparam int unsigned HSYNC   = 0;
  localparam int unsigned VSYNC   = 1;
  localparam int unsigned VISIBLE = 2;

  // Pattern value 0 is transparent on both layers.
  function automatic logic is_opaque(input logic [PIX_W-1:0] pix);
    return pix != '0;
  endfunction

  // Palette RAM layout: bit 4 selects sprite half, then palette, then pattern.
  function automatic logic [PAL_ADDR_W-1:0] pal_entry(
    input logic             is_spr,
    input logic [PIX_W-1:0] pal,
    input logic [PIX_W-1:0] pix
  );
    return {is_spr, pal, pix};
  endfunction

endpackage

// File: rtl/nes_pix_prio_mux.sv
// Background/sprite priority and transparency resolution (combinational).
module nes_pix_prio_mux
  import nes_ppu_pkg::*;
(
  input  logic [PIX_W-1:0]      bg_pix,
  input  logic [PIX_W-1:0]      bg_pal,
  input  logic [PIX_W-1:0]      spr_pix,
  input  logic [PIX_W-1:0]      spr_pal,
  input  logic                  spr_behind,
  output logic [PAL_ADDR_W-1:0] addr_c,
  output logic                  both_opaque_c
);

  logic bg_op_c;
  logic spr_op_c;

  assign bg_op_c  = is_opaque(bg_pix);
  assign spr_op_c = is_opaque(spr_pix);

  // Pick the winning layer; fully transparent pixels fall back to the backdrop.
  always_comb begin
    addr_c        = BACKDROP_ADDR;
    both_opaque_c = bg_op_c & spr_op_c;
    unique case ({bg_op_c, spr_op_c})
      2'b10:   addr_c = pal_entry(1'b0, bg_pal, bg_pix);
      2'b01:   addr_c = pal_entry(1'b1, spr_pal, spr_pix);
      2'b11:   addr_c = spr_behind ? pal_entry(1'b0, bg_pal, bg_pix)
                                   : pal_entry(1'b1, spr_pal, spr_pix);
      default: addr_c = BACKDROP_ADDR;
    endcase
  end

endmodule

// File: rtl/nes_pix_pal_pipe.sv
// Pixel composition in front of the 32-entry palette ROM: resolves priority,
// drives the ROM address, re-aligns the returned colour with the sidebands and
// tracks the sticky sprite-0 hit. Optional grayscale via NES_PIX_GRAYSCALE_EN.
module nes_pix_pal_pipe
  import nes_ppu_pkg::*;
#(
  parameter  int unsigned SYNC_W   = 3,
  localparam int unsigned PIPE_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_ce,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      bg_pix,
  input  logic [PIX_W-1:0]      bg_pal,
  input  logic [PIX_W-1:0]      spr_pix,
  input  logic [PIX_W-1:0]      spr_pal,
  input  logic                  spr_behind,
  input  logic                  spr_zero,
  input  logic [SYNC_W-1:0]     sync_in,
  input  logic                  frame_start,
`ifdef NES_PIX_GRAYSCALE_EN
  input  logic                  gray,
`endif
  output logic [PAL_ADDR_W-1:0] pal_addr,
  input  logic [7:0]            pal_dout,
  output logic                  out_valid,
  output logic [COLOR_W-1:0]    out_color,
  output logic [SYNC_W-1:0]     sync_out,
  output logic                  spr0_hit
);

  logic [PAL_ADDR_W-1:0]          addr_c;
  logic                           both_opaque_c;
  logic                           hit_c;
  logic [PIPE_LAT-1:0]            vld_sr;
  logic [PIPE_LAT-1:0][SYNC_W-1:0] sync_sr;
  logic                           ce_d;
  logic [COLOR_W-1:0]             dout_hold;
  logic [COLOR_W-1:0]             rom_color_c;
  logic [COLOR_W-1:0]             color_c;
  logic                           unused_rom_hi;

  assign unused_rom_hi = ^pal_dout[7:COLOR_W];

  nes_pix_prio_mux u_prio_mux (
    .bg_pix        (bg_pix),
    .bg_pal        (bg_pal),
    .spr_pix       (spr_pix),
    .spr_pal       (spr_pal),
    .spr_behind    (spr_behind),
    .addr_c        (addr_c),
    .both_opaque_c (both_opaque_c)
  );

  // S1: palette address register; invalid pixels park on the backdrop entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_addr <= BACKDROP_ADDR;
    end else if (pix_ce) begin
      pal_addr <= in_valid ? addr_c : BACKDROP_ADDR;
    end
  end

  // S1..S3: valid/sideband delay line, one tap per pixel-enable edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      sync_sr <= '0;
    end else if (pix_ce) begin
      vld_sr  <= {vld_sr[PIPE_LAT-2:0], in_valid};
      sync_sr <= {sync_sr[PIPE_LAT-2:0], sync_in};
    end
  end

  assign out_valid = vld_sr[PIPE_LAT-1];
  assign sync_out  = sync_sr[PIPE_LAT-1];

  // ROM data for the S2 address is on pal_dout one clk after the S2 edge;
  // with sparse enables the address moves on before S3, so that value is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_d      <= 1'b0;
      dout_hold <= '0;
    end else begin
      ce_d <= pix_ce;
      if (ce_d) begin
        dout_hold <= pal_dout[COLOR_W-1:0];
      end
    end
  end

  assign rom_color_c = ce_d ? pal_dout[COLOR_W-1:0] : dout_hold;

`ifdef NES_PIX_GRAYSCALE_EN
  logic [PIPE_LAT-2:0] gray_sr;

  // Gray request travels with its pixel through S1 and S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_sr <= '0;
    end else if (pix_ce) begin
      gray_sr <= {gray_sr[PIPE_LAT-3:0], gray};
    end
  end

  // Grayscale keeps only the luma bits of the ROM colour.
  always_comb begin
    color_c = rom_color_c;
    if (gray_sr[PIPE_LAT-2]) begin
      color_c = rom_color_c & GRAY_MASK;
    end
  end
`else
  // Colour passes through untouched in the default build.
  always_comb begin
    color_c = rom_color_c;
  end
`endif

  // S3: final colour register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_color <= '0;
    end else if (pix_ce) begin
      out_color <= color_c;
    end
  end

  assign hit_c = pix_ce & in_valid & spr_zero & both_opaque_c & sync_in[VISIBLE];

  // Sticky sprite-0 hit; frame_start is sampled every clk and beats a new hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr0_hit <= 1'b0;
    end else if (frame_start) begin
      spr0_hit <= 1'b0;
    end else if (hit_c) begin
      spr0_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nes_pix_pal_pipe.sv
// Self-checking bench for nes_pix_pal_pipe with a behavioural palette model.
// Honours NES_PIX_GRAYSCALE_EN when the design is built with it.
module tb_nes_pix_pal_pipe;

`ifdef NES_PIX_GRAYSCALE_EN
  localparam bit GRAY_EN = 1'b1;
`else
  localparam bit GRAY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_ce = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] bg_pix = '0, bg_pal = '0, spr_pix = '0, spr_pal = '0;
  logic       spr_behind = 1'b0, spr_zero = 1'b0, frame_start = 1'b0, gray = 1'b0;
  logic [2:0] sync_in = '0;

  logic [4:0] pal_addr;
  logic [7:0] pal_dout;
  logic       out_valid;
  logic [5:0] out_color;
  logic [2:0] sync_out;
  logic       spr0_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nes_pix_pal_pipe #(.SYNC_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .in_valid    (in_valid),
    .bg_pix      (bg_pix),
    .bg_pal      (bg_pal),
    .spr_pix     (spr_pix),
    .spr_pal     (spr_pal),
    .spr_behind  (spr_behind),
    .spr_zero    (spr_zero),
    .sync_in     (sync_in),
    .frame_start (frame_start),
`ifdef NES_PIX_GRAYSCALE_EN
    .gray        (gray),
`endif
    .pal_addr    (pal_addr),
    .pal_dout    (pal_dout),
    .out_valid   (out_valid),
    .out_color   (out_color),
    .sync_out    (sync_out),
    .spr0_hit    (spr0_hit)
  );

  // Palette ROM: 1-clk registered read; upper bits carry junk to be ignored.
  logic [7:0] rom [32];
  always @(posedge clk) pal_dout <= rom[pal_addr];

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [5:0] c;
    logic [2:0] s;
  } out_t;

  out_t       mq[$];
  out_t       m_out;
  logic [4:0] m_addr;
  logic       m_hit;

  function automatic logic [4:0] ref_addr(input logic v, input logic [1:0] bp, input logic [1:0] bpal,
                                          input logic [1:0] sp, input logic [1:0] spal, input logic beh);
    bit bo = (bp != 2'd0);
    bit so = (sp != 2'd0);
    if (!v) return 5'h00;
    if (!bo && !so) return 5'h00;
    if (bo && (!so || beh)) return {1'b0, bpal, bp};
    return {1'b1, spal, sp};
  endfunction

  always @(posedge clk or posedge rst) begin
    out_t e;
    if (rst) begin
      mq.delete();
      mq.push_back('0);
      mq.push_back('0);
      m_out  = '0;
      m_addr = '0;
      m_hit  = 1'b0;
    end else begin
      if (frame_start) m_hit = 1'b0;
      else if (pix_ce && in_valid && spr_zero && bg_pix != 0 && spr_pix != 0 && sync_in[2]) m_hit = 1'b1;
      if (pix_ce) begin
        m_addr = ref_addr(in_valid, bg_pix, bg_pal, spr_pix, spr_pal, spr_behind);
        e.v = in_valid;
        e.c = rom[m_addr][5:0] & ((GRAY_EN && gray) ? 6'h30 : 6'h3f);
        e.s = sync_in;
        mq.push_back(e);
        m_out = mq.pop_front();
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("pal_addr", 32'(pal_addr), 32'(m_addr));
    chk("out_valid", 32'(out_valid), 32'(m_out.v));
    chk("sync_out", 32'(sync_out), 32'(m_out.s));
    if (m_out.v) chk("out_color", 32'(out_color), 32'(m_out.c));
    chk("spr0_hit", 32'(spr0_hit), 32'(m_hit));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    in_valid = 1'b0; bg_pix = '0; bg_pal = '0; spr_pix = '0; spr_pal = '0;
    spr_behind = 1'b0; spr_zero = 1'b0; sync_in = '0; gray = 1'b0; frame_start = 1'b0;
  endtask

  task automatic directed(input string name, input logic [1:0] bp, input logic [1:0] bpal,
                          input logic [1:0] sp, input logic [1:0] spal, input logic beh,
                          input logic gr, input logic [4:0] ea, input logic [5:0] ec);
    pix_ce = 1'b1; in_valid = 1'b1; bg_pix = bp; bg_pal = bpal; spr_pix = sp; spr_pal = spal;
    spr_behind = beh; spr_zero = 1'b0; sync_in = 3'b101; gray = gr;
    tick();
    chk({name, "_addr"}, 32'(pal_addr), 32'(ea));
    chk({name, "_model_addr"}, 32'(m_addr), 32'(ea));
    idle();
    tick();
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_color"}, 32'(out_color), 32'(ec));
    chk({name, "_model_color"}, 32'(m_out.c), 32'(ec));
    chk({name, "_sync"}, 32'(sync_out), 32'h5);
  endtask

  task automatic randomize_inputs();
    in_valid    = ($urandom_range(0, 9) < 8);
    bg_pix      = 2'($urandom); bg_pal = 2'($urandom);
    spr_pix     = 2'($urandom); spr_pal = 2'($urandom);
    spr_behind  = 1'($urandom);
    spr_zero    = ($urandom_range(0, 2) == 0);
    sync_in     = 3'($urandom);
    frame_start = ($urandom_range(0, 40) == 0);
    gray        = GRAY_EN ? 1'($urandom) : 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    rom[0]  = 8'hB1;  // colour 0x31
    rom[2]  = 8'h2B;  // colour 0x2B
    rom[5]  = 8'hED;  // colour 0x2D
    rom[17] = 8'h52;  // colour 0x12

    repeat (3) tick();
    chk("rst_pal_addr", 32'(pal_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_color", 32'(out_color), 32'd0);
    chk("rst_sync_out", 32'(sync_out), 32'd0);
    chk("rst_spr0_hit", 32'(spr0_hit), 32'd0);
    rst = 1'b0;
    tick();

    directed("bg_only",    2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 5'h05, 6'h2D);
    directed("spr_front",  2'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 5'h11, 6'h12);
    directed("spr_behind", 2'd2, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 5'h02, 6'h2B);
    directed("backdrop",   2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 5'h00, 6'h31);
    if (GRAY_EN) directed("gray", 2'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 5'h11, 6'h10);

    // Sprite-0 hit: set, sticky, clear, clear beats set, not outside visible area.
    pix_ce = 1'b1; in_valid = 1'b1; bg_pix = 2'd1; spr_pix = 2'd2; spr_behind = 1'b1;
    spr_zero = 1'b1; sync_in = 3'b100;
    tick();
    chk("hit_set", 32'(spr0_hit), 32'd1);
    spr_zero = 1'b0;
    repeat (3) tick();
    chk("hit_sticky", 32'(spr0_hit), 32'd1);
    frame_start = 1'b1;
    tick();
    chk("hit_clear", 32'(spr0_hit), 32'd0);
    spr_zero = 1'b1;
    tick();
    chk("hit_clear_wins", 32'(spr0_hit), 32'd0);
    frame_start = 1'b0; sync_in = 3'b011;
    tick();
    chk("hit_not_visible", 32'(spr0_hit), 32'd0);
    sync_in = 3'b100;
    tick();
    chk("hit_set_again", 32'(spr0_hit), 32'd1);
    pix_ce = 1'b0; spr_zero = 1'b0; frame_start = 1'b1;
    tick();
    chk("hit_clear_no_ce", 32'(spr0_hit), 32'd0);
    idle();

    // Sparse enable ramp: one ce per 4 clks, stream held between enables.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; bg_pix = 2'((i % 3) + 1); bg_pal = 2'(i);
      spr_pix = 2'(i >> 1); spr_pal = 2'(i + 1); spr_behind = (i >= 4); sync_in = 3'(i);
      for (int j = 0; j < 4; j++) begin
        pix_ce = (j == 0);
        tick();
      end
    end
    idle();
    for (int j = 0; j < 12; j++) begin
      pix_ce = (j % 4 == 0);
      tick();
    end

    // Random traffic with varying enable density and a mid-stream async reset.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      pix_ce = (n < 1500) ? 1'($urandom) : (n < 2200) ? 1'b1 : ($urandom_range(0, 3) == 0);
      tick();
      if (n == 1200) begin
        in_valid = 1'b1; bg_pix = 2'd3; spr_pix = 2'd1; spr_zero = 1'b1; sync_in = 3'b111;
        pix_ce = 1'b1; frame_start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pal_addr", 32'(pal_addr), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_color", 32'(out_color), 32'd0);
        chk("async_rst_sync_out", 32'(sync_out), 32'd0);
        chk("async_rst_spr0_hit", 32'(spr0_hit), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_pix_pal_pipe.md
Name: nes_pix_pal_pipe

Overview:
- Pixel-composition stage directly upstream of the 32-entry palette ROM (5-bit addr in, 8-bit dout, 1-clk registered read).
- Takes per-pixel background and sprite pattern/attribute bits and resolves priority and transparency.
- Forms the palette address, drives the ROM, and re-aligns the returned NES colour index (6 bit) with the video sync/valid sidebands for the downstream RGB/VGA stage.
- Also performs sprite-0 hit detection.

Parameters:
- SYNC_W, 3, number of sideband bits delayed alongside pixels (hsync, vsync, visible).
- PIPE_LAT, 3, pix_ce edges from input to output; fixed, exposed read-only for consumers, must not be overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel clock enable; pipeline advances only on clk edges with pix_ce=1
- in_valid  in  1  input pixel valid
- bg_pix  in  2  background pattern bits (0 = transparent)
- bg_pal  in  2  background attribute palette select
- spr_pix  in  2  sprite pattern bits (0 = transparent)
- spr_pal  in  2  sprite palette select
- spr_behind  in  1  sprite priority bit (1 = behind opaque background)
- spr_zero  in  1  current sprite pixel belongs to sprite 0
- sync_in  in  SYNC_W  sideband bits aligned with input pixel
- frame_start  in  1  one-clk pulse at the start of a frame; clears hit flag
- pal_addr  out  5  palette ROM address
- pal_dout  in  8  palette ROM data (valid 1 clk after pal_addr)
- out_valid  out  1  colour output valid
- out_color  out  6  NES colour index
- sync_out  out  SYNC_W  sidebands delayed by PIPE_LAT
- spr0_hit  out  1  sticky sprite-0 hit flag

Behaviour:
- Reset (async): pal_addr=0, out_valid=0, out_color=0, sync_out=0, spr0_hit=0, all internal stage registers 0.
- Pipeline stages advance only on pix_ce edges. When pix_ce=0, every register holds.
- S1 (first ce edge), priority resolution:
  - bg opaque = bg_pix≠0; spr opaque = spr_pix≠0.
  - Both transparent: addr=5'h00 (universal backdrop).
  - Only bg opaque: addr={1'b0,bg_pal,bg_pix}.
  - Only spr opaque: addr={1'b1,spr_pal,spr_pix}.
  - Both opaque: spr_behind=1 selects bg, otherwise spr.
  - pal_addr is the S1 register; in_valid and sync_in are captured with it.
  - When in_valid=0, pal_addr is forced to 0.
- Address generation never emits 5'h10/14/18/1C. Those are produced only via the backdrop rule, so no mirroring is needed in the ROM.
- S2 (second ce edge): pure delay of valid/sync. The ROM output settles during this interval.
- S3 (third ce edge): out_color <= pal_dout[5:0]; out_valid/sync_out updated. pal_dout[7:6] are ignored.
- Latency: exactly 3 pix_ce edges. Correct for contiguous or sparse pix_ce, because the ROM has ≥1 clk between the S1 and S3 edges.
- Sprite-0 hit:
  - Set at S1 when in_valid, spr_zero, bg opaque, spr opaque, and sync_in[2] (visible). Set regardless of spr_behind.
  - Sticky until frame_start.
  - frame_start is sampled every clk, independent of pix_ce. It overrides a simultaneous set: clear wins.
- Reset mid-frame: everything clears immediately. The first valid output appears 3 ce edges after the first in_valid following deassertion.

Optional Feature:
- Macro: NES_PIX_GRAYSCALE_EN.
- Defined: adds input port gray (1 bit), registered in S1 and delayed to S3. When the delayed gray bit is 1, out_color = pal_dout[5:0] & 6'h30.
- Undefined: no gray port; out_color passes the ROM value unchanged.

Decomposition:
- Shared package nes_ppu_pkg:
  - widths: PAL_ADDR_W=5, COLOR_W=6, PIX_W=2
  - constant BACKDROP_ADDR=5'h00
  - constant GRAY_MASK=6'h30
  - sideband bit indices: HSYNC=0, VSYNC=1, VISIBLE=2
- One natural combinational sub-module: nes_pix_prio_mux. It holds the priority/transparency resolution and produces the address plus the both-opaque flag for hit detection.
- Registers and sticky flag live in the top.

Test Plan (ROM_PALETTE_NOVA attached):
- bg_pix=1, bg_pal=1, spr_pix=0, pix_ce=1 each clk -> pal_addr=5'h05 after 1 edge; out_color=6'h2D, out_valid=1 exactly 3 edges after input.
- bg_pix=2, bg_pal=0 and spr_pix=1, spr_pal=0, spr_behind=0 -> addr 5'h11, out_color=6'h12. Same with spr_behind=1 -> addr 5'h02, out_color=6'h2B.
- Both transparent, spr_pal=1 -> addr 5'h00, out_color=6'h31 (never 5'h14).
- pix_ce high every 4th clk, ramp of 8 pixels -> outputs in order, each 3 ce edges later, sync_out aligned; the stream is held unchanged while pix_ce=0.
- spr_zero=1, both opaque, visible=1 -> spr0_hit rises next edge and stays; frame_start -> clears; frame_start coincident with new hit -> stays 0.
- rst asserted mid-stream, asynchronously between clk edges -> all outputs 0 immediately. With NES_PIX_GRAYSCALE_EN, gray=1, addr 5'h11 -> out_color=6'h10.
